// File: rtl/axis_packet_fifo.sv
// Single-clock AXI4-Stream FIFO with optional store-and-forward packet mode.
// Bad-frame packets and packets larger than the FIFO are dropped before the consumer sees them.
module axis_packet_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_DEPTH  = 4,
    parameter int PACKET_MODE = 1
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    input  logic                    s_tuser,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic [ADDR_DEPTH:0]     fill_count,
    output logic                    pkt_good,
    output logic                    pkt_drop
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int WORD_W = 1 + KEEP_W + DATA_WIDTH;
    localparam int PTR_W  = ADDR_DEPTH + 1;
    localparam int DEPTH  = 1 << ADDR_DEPTH;

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } state_t;

    logic [WORD_W-1:0] mem [DEPTH];

    state_t     state, state_next;
    logic [PTR_W-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_ptr_next, commit_ptr_next, rd_ptr_next;
    logic [PTR_W-1:0] level, pend_level;
    logic             full, oversize_cond;
    logic             wr_en, rd_en, store_beat;
    logic             pkt_good_next, pkt_drop_next;

    assign level      = wr_ptr - rd_ptr;
    assign pend_level = wr_ptr - commit_ptr;
    assign full       = (level == PTR_W'(DEPTH));

    // The whole FIFO holds one unfinished packet: it can never commit, so keep accepting and discard.
    assign oversize_cond = (PACKET_MODE != 0) && full && (pend_level == PTR_W'(DEPTH));

    assign s_tready   = ~areset & (~full | (state == DROP) | oversize_cond);
    assign wr_en      = s_tvalid & s_tready;
    assign m_tvalid   = (rd_ptr != commit_ptr);
    assign rd_en      = m_tvalid & m_tready;
    assign fill_count = level;

    assign {m_tlast, m_tkeep, m_tdata} = mem[rd_ptr[ADDR_DEPTH-1:0]];

    always_comb begin
        state_next      = state;
        wr_ptr_next     = wr_ptr;
        commit_ptr_next = commit_ptr;
        rd_ptr_next     = rd_ptr;
        store_beat      = 1'b0;
        pkt_good_next   = 1'b0;
        pkt_drop_next   = 1'b0;

        if (rd_en) begin
            rd_ptr_next = rd_ptr + PTR_W'(1);
        end

        if (wr_en) begin
            if (PACKET_MODE == 0) begin
                store_beat      = 1'b1;
                wr_ptr_next     = wr_ptr + PTR_W'(1);
                commit_ptr_next = wr_ptr + PTR_W'(1);
            end else begin
                case (state)
                    ACCEPT: begin
                        if (oversize_cond) begin
                            wr_ptr_next = commit_ptr;
                            if (s_tlast) begin
                                pkt_drop_next = 1'b1;
                            end else begin
                                state_next = DROP;
                            end
                        end else if (s_tlast && s_tuser) begin
                            wr_ptr_next   = commit_ptr;
                            pkt_drop_next = 1'b1;
                        end else begin
                            store_beat  = 1'b1;
                            wr_ptr_next = wr_ptr + PTR_W'(1);
                            if (s_tlast) begin
                                commit_ptr_next = wr_ptr + PTR_W'(1);
                                pkt_good_next   = 1'b1;
                            end
                        end
                    end
                    DROP: begin
                        if (s_tlast) begin
                            pkt_drop_next = 1'b1;
                            state_next    = ACCEPT;
                        end
                    end
                    default: state_next = ACCEPT;
                endcase
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= ACCEPT;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pkt_good   <= 1'b0;
            pkt_drop   <= 1'b0;
        end else begin
            state      <= state_next;
            wr_ptr     <= wr_ptr_next;
            commit_ptr <= commit_ptr_next;
            rd_ptr     <= rd_ptr_next;
            pkt_good   <= pkt_good_next;
            pkt_drop   <= pkt_drop_next;
        end
    end

    // Storage is not reset; stale words are hidden because m_tvalid gates them.
    always_ff @(posedge aclk) begin
        if (store_beat) begin
            mem[wr_ptr[ADDR_DEPTH-1:0]] <= {s_tlast, s_tkeep, s_tdata};
        end
    end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: packet-mode and plain-mode instances share stimulus and are
// compared each cycle against queue-based models of committed, pending and dropped data.
module tb_axis_packet_fifo;

    localparam int DW     = 8;
    localparam int KW     = DW / 8;
    localparam int AD     = 4;
    localparam int DEPTH  = 1 << AD;
    localparam int WORD_W = 1 + KW + DW;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tuser = 1'b0;
    logic          m_tready = 1'b0;

    logic          s_tready1, m_tvalid1, m_tlast1, pkt_good1, pkt_drop1;
    logic [DW-1:0] m_tdata1;
    logic [KW-1:0] m_tkeep1;
    logic [AD:0]   fill_count1;

    logic          s_tready0, m_tvalid0, m_tlast0, pkt_good0, pkt_drop0;
    logic [DW-1:0] m_tdata0;
    logic [KW-1:0] m_tkeep0;
    logic [AD:0]   fill_count0;

    int error_count = 0;
    int check_count = 0;

    axis_packet_fifo #(.DATA_WIDTH(DW), .ADDR_DEPTH(AD), .PACKET_MODE(1)) dut_pkt (
        .aclk(aclk), .areset(areset),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tready(s_tready1),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tdata(m_tdata1), .m_tkeep(m_tkeep1), .m_tvalid(m_tvalid1), .m_tready(m_tready),
        .m_tlast(m_tlast1), .fill_count(fill_count1), .pkt_good(pkt_good1), .pkt_drop(pkt_drop1)
    );

    axis_packet_fifo #(.DATA_WIDTH(DW), .ADDR_DEPTH(AD), .PACKET_MODE(0)) dut_plain (
        .aclk(aclk), .areset(areset),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tready(s_tready0),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tdata(m_tdata0), .m_tkeep(m_tkeep0), .m_tvalid(m_tvalid0), .m_tready(m_tready),
        .m_tlast(m_tlast0), .fill_count(fill_count0), .pkt_good(pkt_good0), .pkt_drop(pkt_drop0)
    );

    always #5 aclk = ~aclk;

    // Reference state: words visible to the consumer, words of the open packet, drop mode and pulses.
    logic [WORD_W-1:0] q1_commit[$];
    logic [WORD_W-1:0] q1_pend[$];
    logic [WORD_W-1:0] q0[$];
    bit dropping = 0;
    bit exp_good = 0;
    bit exp_drop = 0;
    bit in_reset = 1;

    function automatic bit m1_ready();
        int fill = q1_commit.size() + q1_pend.size();
        if (in_reset) return 0;
        if (fill < DEPTH) return 1;
        if (dropping) return 1;
        return (q1_pend.size() == DEPTH);
    endfunction

    function automatic bit m0_ready();
        return !in_reset && (q0.size() < DEPTH);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_all();
        checkOutput("pkt_s_tready", 64'(s_tready1), 64'(m1_ready()));
        checkOutput("pkt_m_tvalid", 64'(m_tvalid1), 64'(q1_commit.size() != 0));
        if (q1_commit.size() != 0)
            checkOutput("pkt_m_word", 64'({m_tlast1, m_tkeep1, m_tdata1}), 64'(q1_commit[0]));
        checkOutput("pkt_fill", 64'(fill_count1), 64'(q1_commit.size() + q1_pend.size()));
        checkOutput("pkt_good", 64'(pkt_good1), 64'(exp_good));
        checkOutput("pkt_drop", 64'(pkt_drop1), 64'(exp_drop));
        checkOutput("plain_s_tready", 64'(s_tready0), 64'(m0_ready()));
        checkOutput("plain_m_tvalid", 64'(m_tvalid0), 64'(q0.size() != 0));
        if (q0.size() != 0)
            checkOutput("plain_m_word", 64'({m_tlast0, m_tkeep0, m_tdata0}), 64'(q0[0]));
        checkOutput("plain_fill", 64'(fill_count0), 64'(q0.size()));
        checkOutput("plain_pulses", 64'({pkt_good0, pkt_drop0}), 64'(0));
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the models with the rising edge.
    task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                                 input bit l, input bit u, input bit r, output bit accepted);
        bit wr1, rd1, wr0, rd0;
        logic [WORD_W-1:0] word;
        s_tvalid = v; s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; m_tready = r;
        #1;
        check_all();
        wr1 = v && m1_ready();
        rd1 = r && (q1_commit.size() != 0);
        wr0 = v && m0_ready();
        rd0 = r && (q0.size() != 0);
        word = {l, k, d};
        accepted = wr1;
        @(posedge aclk);
        exp_good = 0;
        exp_drop = 0;
        if (rd1) void'(q1_commit.pop_front());
        if (wr1) begin
            if (dropping) begin
                if (l) begin exp_drop = 1; dropping = 0; end
            end else if (q1_pend.size() == DEPTH) begin
                q1_pend.delete();
                if (l) exp_drop = 1; else dropping = 1;
            end else if (l && u) begin
                q1_pend.delete();
                exp_drop = 1;
            end else begin
                q1_pend.push_back(word);
                if (l) begin
                    foreach (q1_pend[i]) q1_commit.push_back(q1_pend[i]);
                    q1_pend.delete();
                    exp_good = 1;
                end
            end
        end
        if (rd0) void'(q0.pop_front());
        if (wr0) q0.push_back(word);
        @(negedge aclk);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        #1;
        in_reset = 1;
        q1_commit.delete(); q1_pend.delete(); q0.delete();
        dropping = 0; exp_good = 0; exp_drop = 0;
        checkOutput("rst_pkt_m_tvalid", 64'(m_tvalid1), 64'(0));
        checkOutput("rst_pkt_fill", 64'(fill_count1), 64'(0));
        checkOutput("rst_pkt_s_tready", 64'(s_tready1), 64'(0));
        checkOutput("rst_plain_m_tvalid", 64'(m_tvalid0), 64'(0));
        checkOutput("rst_plain_fill", 64'(fill_count0), 64'(0));
        checkOutput("rst_plain_s_tready", 64'(s_tready0), 64'(0));
        checkOutput("rst_pulses", 64'({pkt_good1, pkt_drop1}), 64'(0));
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        in_reset = 0;
    endtask

    task automatic send_packet(input int len, input logic [DW-1:0] first, input bit bad, input bit hold_read);
        bit acc;
        int tries;
        for (int i = 0; i < len; i++) begin
            tries = 0;
            acc = 0;
            while (!acc && tries < 50) begin
                applyStimulus(1, first + DW'(i), '1, i == len - 1, bad && (i == len - 1), !hold_read, acc);
                tries++;
            end
            if (!acc) checkOutput("send_timeout", 64'(0), 64'(1));
        end
    endtask

    task automatic idle(input int n, input bit r);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, 0, r, acc);
    endtask

    initial begin
        bit acc;
        int vp, lp, bp, rp;
        @(negedge aclk);
        do_reset();

        // Good 4-beat packet held back, then drained.
        send_packet(4, 8'h01, 0, 1);
        idle(8, 1);
        // Bad 3-beat packet followed by a good 2-beat packet.
        send_packet(3, 8'h30, 1, 1);
        send_packet(2, 8'hA0, 0, 1);
        idle(6, 1);
        // 20-beat oversize packet, then a short packet that must pass intact.
        send_packet(20, 8'h40, 0, 1);
        idle(2, 1);
        send_packet(2, 8'hC0, 0, 1);
        idle(6, 1);
        // Exactly DEPTH words is still a legal packet.
        send_packet(DEPTH, 8'h60, 0, 1);
        idle(DEPTH + 2, 1);
        // Reset with five words of an open packet stored.
        for (int i = 0; i < 5; i++) applyStimulus(1, DW'(8'h70 + i), '1, 0, 0, 0, acc);
        do_reset();
        idle(2, 1);

        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: begin vp = 70;  lp = 25; bp = 25; rp = 70;  end
                1: begin vp = 90;  lp = 4;  bp = 10; rp = 80;  end
                2: begin vp = 80;  lp = 15; bp = 20; rp = 0;   end
                3: begin vp = 100; lp = 20; bp = 0;  rp = 100; end
                4: begin vp = 50;  lp = 30; bp = 50; rp = 30;  end
                default: begin vp = 90; lp = 2; bp = 0; rp = 50; end
            endcase
            for (int c = 0; c < 400; c++) begin
                if (ph == 4 && c == 200) do_reset();
                applyStimulus(($urandom % 100) < vp, DW'($urandom), KW'($urandom),
                              ($urandom % 100) < lp, ($urandom % 100) < bp,
                              ($urandom % 100) < rp, acc);
            end
        end
        idle(DEPTH + 4, 1);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
